// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
package ring_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  localparam int unsigned RING_N_DEFAULT        = 4;
  localparam int unsigned RING_MAX_HOLD_DEFAULT = 16;

  // Widest ring rotl supports; callers zero-extend and truncate to their own N.
  localparam int unsigned RING_MAXW = 64;
  localparam int unsigned RING_IDXW = $clog2(RING_MAXW);

  function automatic logic [RING_MAXW-1:0] rotl(input logic [RING_MAXW-1:0] v,
                                                input int unsigned n);
    logic [RING_MAXW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < RING_MAXW; i++) begin
      if (i < n) r[RING_IDXW'((i + 1) % n)] = v[RING_IDXW'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface ring_rr_arbiter_if
  import ring_arb_pkg::*;
#(
  parameter int unsigned N = RING_N_DEFAULT
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_id;
  logic [N-1:0]  ptr;
  logic          timeout;

  modport master (output req, input gnt, gnt_valid, gnt_id, ptr, timeout);
  modport slave  (input req, output gnt, gnt_valid, gnt_id, ptr, timeout);
endinterface

// File: rtl/ring_rr_arbiter_pick.sv
// Combinational round-robin pick: first set req bit at or above the one-hot ptr, wrapping.
module rr_priority_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick,
  output logic         any
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic          armed;
  logic          found;
  logic [IW-1:0] idx;

  // Two passes over the ring: the first arms at ptr, the second covers the wrap.
  always_comb begin
    pick  = '0;
    armed = 1'b0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 2 * N; i++) begin
      idx = IW'(i % N);
      if (ptr[idx]) armed = 1'b1;
      if (armed && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/ring_rr_arbiter.sv
// Ring-pointer round-robin arbiter with registered one-hot grant.
// Optional forced release after MAX_HOLD cycles: define RING_RR_ARBITER_TIMEOUT_EN.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int unsigned N        = RING_N_DEFAULT,
  parameter int unsigned MAX_HOLD = RING_MAX_HOLD_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  ring_rr_arbiter_if.slave bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  arb_state_t    state;
  logic [N-1:0]  gnt_q;
  logic [N-1:0]  ptr_q;
  logic          gnt_valid_q;
  logic [IW-1:0] gnt_id_q;

  logic [N-1:0]  rot_owner;
  logic [N-1:0]  pick_req;
  logic [N-1:0]  pick_ptr;
  logic [N-1:0]  pick_gnt;
  logic          pick_any;
  logic [IW-1:0] pick_id;
  logic          owner_req;

  assign owner_req = |(bus.req & gnt_q);
  assign rot_owner = N'(rotl(RING_MAXW'(gnt_q), N));

  // Masking the owner lets one picker serve idle grant, release and forced release:
  // in IDLE gnt_q is zero, and on release the owner bit of req is already clear.
  assign pick_req = bus.req & ~gnt_q;
  assign pick_ptr = (state == GRANT) ? rot_owner : ptr_q;

  rr_priority_pick #(.N(N)) u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .pick(pick_gnt),
    .any (pick_any)
  );

  always_comb begin
    pick_id = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick_gnt[i]) pick_id = IW'(i);
    end
  end

`ifdef RING_RR_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt;
  logic          timeout_q;
`else
  localparam int unsigned unused_max_hold = MAX_HOLD;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr_q       <= N'(1);
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
`ifdef RING_RR_ARBITER_TIMEOUT_EN
      hold_cnt    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef RING_RR_ARBITER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_q       <= pick_gnt;
            gnt_valid_q <= 1'b1;
            gnt_id_q    <= pick_id;
            state       <= GRANT;
`ifdef RING_RR_ARBITER_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
          end
        end
        GRANT: begin
          if (!owner_req) begin
            ptr_q <= rot_owner;
            if (pick_any) begin
              gnt_q       <= pick_gnt;
              gnt_id_q    <= pick_id;
`ifdef RING_RR_ARBITER_TIMEOUT_EN
              hold_cnt    <= '0;
`endif
            end else begin
              gnt_q       <= '0;
              gnt_valid_q <= 1'b0;
              gnt_id_q    <= '0;
              state       <= IDLE;
            end
          end
`ifdef RING_RR_ARBITER_TIMEOUT_EN
          else if (hold_cnt == CW'(MAX_HOLD - 1)) begin
            // Saturated: only hand over if someone else is waiting.
            if (pick_any) begin
              ptr_q     <= rot_owner;
              gnt_q     <= pick_gnt;
              gnt_id_q  <= pick_id;
              hold_cnt  <= '0;
              timeout_q <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.ptr       = ptr_q;
`ifdef RING_RR_ARBITER_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif
endmodule

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
- Round-robin arbiter sharing one resource among N requesters.
- Rotating priority is held as a one-hot ring pointer; a released grant advances it by one-bit rotate-left, so priority is fair.
- Sits in front of shared datapath resources; grant is registered and one-hot, and is held until the owner drops its request.

Parameters:
- N, 4, number of requesters (N >= 2).
- MAX_HOLD, 16, max consecutive grant cycles before forced release (used only with the optional feature; MAX_HOLD >= 1).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i is requester i.
- gnt  output  N  registered one-hot grant, or all-zero.
- gnt_valid  output  1  high when any gnt bit is high.
- gnt_id  output  max(1,$clog2(N))  binary index of the granted requester; 0 when gnt_valid=0.
- ptr  output  N  current one-hot priority pointer (debug/observe).
- timeout  output  1  one-cycle pulse on forced release; tied 0 when the feature is compiled out.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - state=IDLE, ptr=0001 (bit0), gnt=0, gnt_valid=0, gnt_id=0, timeout=0, hold counter=0.
  - Reset overrides everything, including mid-grant; the grant drops at that edge.
- Pick function: the first set bit of req scanning upward from the ptr position, wrapping N-1 -> 0. Pure combinational, one-hot result.
- State IDLE:
  - If req != 0, gnt <= pick(req, ptr); state -> GRANT. Grant appears the cycle after req is first seen high (1-cycle latency).
  - If req == 0, stay in IDLE with gnt=0.
- State GRANT (owner = gnt):
  - req[owner]=1: hold gnt unchanged; ptr unchanged.
  - req[owner]=0 (release): ptr <= rotl(owner), with bit N-1 wrapping to bit0.
    - Same edge: if other requests exist, gnt <= pick(req, rotl(owner)); stay in GRANT. Back-to-back handoff, no dead cycle.
    - Otherwise gnt <= 0; state -> IDLE.
- ptr changes only on release or forced release, never while idle.
- Requests arriving or leaving for non-owners while in GRANT have no effect until release.
- A single requester that drops and re-raises req gets a grant again after one idle cycle; this holds even for the owner's successor.
- gnt_valid and gnt_id are registered consistently with gnt (same edge).
- Invariant: gnt is always one-hot or zero. The bench asserts this every cycle.

Optional Feature:
- Macro: RING_RR_ARBITER_TIMEOUT_EN.
- Defined:
  - The hold counter increments each GRANT cycle and resets on every new grant.
  - When it reaches MAX_HOLD while the owner still requests and any other req bit is set, a forced release happens:
    - ptr <= rotl(owner).
    - gnt <= pick(req & ~owner, rotl(owner)).
    - timeout=1 for that cycle.
  - If no other requester exists, the counter saturates and the grant is held.
- Not defined: no counter, timeout=0 always, and a grant is held indefinitely.

Decomposition:
- Package ring_arb_pkg holds:
  - state enum (IDLE, GRANT);
  - default N and MAX_HOLD constants;
  - a rotl one-hot function.
- Sub-module rr_priority_pick: combinational (req, ptr) -> one-hot pick plus any-flag. It is reused by both the IDLE and release paths.

Test Plan:
- Reset with req=1111 -> at the next edge gnt=0001, gnt_id=0, ptr=0001. Assert reset mid-grant -> gnt=0, ptr=0001 at that edge.
- req=1111 held, each owner drops req for one cycle in turn -> grant order 0,1,2,3,0 with back-to-back handoff; ptr goes 0010, 0100, 1000, 0001.
- Owner 3 releases with req=0001 -> gnt=0001 next edge; ptr=0001 (wrap).
- req=0100 only, ptr=0001 -> gnt=0100 after 1 cycle; release with no other req -> gnt=0, IDLE, ptr=1000.
- Owner holds req while req changes between 0110 and 1010 -> gnt unchanged, ptr unchanged.
- With RING_RR_ARBITER_TIMEOUT_EN, MAX_HOLD=4, req=0011 held -> owner 0 keeps gnt 4 cycles, then timeout pulses, gnt=0010, ptr=0010. With req=0001 only -> grant held with no timeout.
